// File: rtl/sram_rd_id_if.sv
// Read-side bus of the interleaved SRAM reader: configuration/start from the
// controller, read strobe/bank/row and delayed valid back to the consumer.
interface sram_rd_id_if #(
  parameter int CYC_BITWIDTH = 8
);
  logic                    start;
  logic [1:0]              data_type;
  logic [3:0]              sram_num;
  logic [3:0]              data_num;
  logic [CYC_BITWIDTH-1:0] cyc_num;
  logic                    rd_req;
  logic                    rd_en;
  logic [3:0]              rd_id;
  logic [7:0]              rd_addr;
  logic                    rd_valid;
  logic [3:0]              rd_valid_id;
  logic                    done;

  modport master (
    output start, data_type, sram_num, data_num, cyc_num, rd_req,
    input  rd_en, rd_id, rd_addr, rd_valid, rd_valid_id, done
  );

  modport slave (
    input  start, data_type, sram_num, data_num, cyc_num, rd_req,
    output rd_en, rd_id, rd_addr, rd_valid, rd_valid_id, done
  );
endinterface

// File: rtl/sram_rd_id.sv
// Round-robin bank reader: walks data_num items per pass across sram_num banks
// for cyc_num passes, with incremental bank/row/base counters.
module sram_rd_id #(
  parameter int          CYC_BITWIDTH = 8,
  parameter logic [1:0]  DATA_TYPE    = 2'b01
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_rd_id_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              sram_num_q, data_num_q;
  logic [CYC_BITWIDTH-1:0] cyc_num_q, cyc_q;
  logic [3:0]              id_q, row_q, k_q;
  logic [7:0]              base_q;
  logic                    rd_valid_q;
  logic [3:0]              rd_valid_id_q;
  logic                    rd_en, done;
  logic                    cfg_zero, last_item, last_pass;

  // Zero-length check uses the values being latched by this very start.
  assign cfg_zero  = (bus.sram_num == 4'd0) || (bus.data_num == 4'd0) ||
                     (bus.cyc_num == '0);
  assign last_item = (k_q == data_num_q - 4'd1);
  assign last_pass = (cyc_q == cyc_num_q - CYC_BITWIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = cfg_zero ? DONE : RUN;
    end else begin
      unique case (state_q)
        RUN:     if (rd_en && last_item && last_pass) state_d = DRAIN;
        DRAIN:   state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rd_en = (state_q == RUN) && bus.rd_req && (bus.data_type == DATA_TYPE);
    done  = (state_q == DONE);
  end

  // start outranks a read issued in the same cycle: that advance is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_num_q    <= '0;
      data_num_q    <= '0;
      cyc_num_q     <= '0;
      cyc_q         <= '0;
      id_q          <= '0;
      row_q         <= '0;
      k_q           <= '0;
      base_q        <= '0;
      rd_valid_q    <= 1'b0;
      rd_valid_id_q <= '0;
    end else begin
      rd_valid_q    <= rd_en;
      rd_valid_id_q <= id_q;
      if (bus.start) begin
        sram_num_q <= bus.sram_num;
        data_num_q <= bus.data_num;
        cyc_num_q  <= bus.cyc_num;
        cyc_q      <= '0;
        id_q       <= '0;
        row_q      <= '0;
        k_q        <= '0;
        base_q     <= '0;
      end else if (rd_en) begin
        if (last_item) begin
          id_q   <= '0;
          row_q  <= '0;
          k_q    <= '0;
          base_q <= base_q + {4'b0, row_q} + 8'd1;
          cyc_q  <= cyc_q + CYC_BITWIDTH'(1);
        end else begin
          k_q <= k_q + 4'd1;
          if (id_q == sram_num_q - 4'd1) begin
            id_q  <= '0;
            row_q <= row_q + 4'd1;
          end else begin
            id_q <= id_q + 4'd1;
          end
        end
      end
    end
  end

  assign bus.rd_en       = rd_en;
  assign bus.done        = done;
  assign bus.rd_id       = id_q;
  assign bus.rd_addr     = base_q + {4'b0, row_q};
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_valid_id = rd_valid_id_q;

endmodule

// File: tb/tb_sram_rd_id.sv
// Scoreboard bench for sram_rd_id: expected reads come from a pass/item model,
// a negedge monitor pops and compares every rd_en and rd_valid.
module tb_sram_rd_id;
  localparam int         CW = 8;
  localparam logic [1:0] DT = 2'b01;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_rd_id_if #(.CYC_BITWIDTH(CW)) bus ();
  sram_rd_id #(.CYC_BITWIDTH(CW), .DATA_TYPE(DT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed { logic [3:0] id; logic [7:0] addr; } rd_t;
  rd_t         exp_q[$];
  logic [3:0]  vid_q[$];
  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc_cnt = 0, last_en_cyc = 0, rd_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: item k of every pass -> bank k%s, row base+k/s; base grows by rows used.
  function automatic void build(input int s, input int d, input int c);
    int base = 0;
    rd_t e;
    exp_q.delete();
    if (s == 0 || d == 0 || c == 0) return;
    for (int p = 0; p < c; p++) begin
      for (int k = 0; k < d; k++) begin
        e.id   = 4'(k % s);
        e.addr = 8'((base + k / s) % 256);
        exp_q.push_back(e);
      end
      base += (d - 1) / s + 1;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en) begin
        rd_cnt++;
        last_en_cyc = cyc_cnt;
        check("rd_en_qualified", {29'd0, bus.rd_req, bus.data_type}, {29'd0, 1'b1, DT});
        if (exp_q.size() == 0) check("rd_en_unexpected", bus.rd_en, 0);
        else begin
          rd_t e;
          e = exp_q.pop_front();
          check("rd_id", bus.rd_id, e.id);
          check("rd_addr", bus.rd_addr, e.addr);
          vid_q.push_back(e.id);
        end
      end
      if (bus.rd_valid) begin
        if (vid_q.size() == 0) check("rd_valid_unexpected", bus.rd_valid, 0);
        else check("rd_valid_id", bus.rd_valid_id, vid_q.pop_front());
      end
    end
  end

  task automatic drive(input bit stall);
    bus.rd_req    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.data_type = (stall && $urandom_range(0, 3) == 0) ? 2'b10 : DT;
    bus.sram_num  = 4'($urandom);
    bus.data_num  = 4'($urandom);
    bus.cyc_num   = CW'($urandom);
  endtask

  // Pulse start; the model takes over once start has been sampled.
  task automatic do_start(input int s, input int d, input int c);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.sram_num = 4'(s);
    bus.data_num = 4'(d);
    bus.cyc_num  = CW'(c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    build(s, d, c);
    rd_cnt = 0;
  endtask

  task automatic run_to_done(input int d, input int c, input bit stall);
    int unsigned n = 0;
    int unsigned bound = d * c * 10 + 20;
    forever begin
      drive(stall);
      @(negedge clk); #1;
      if (bus.done || n >= bound) break;
      n++;
      @(posedge clk); #1;
    end
    check("done_reached", bus.done, 1);
    check("read_count", rd_cnt, d * c);
    check("done_latency", cyc_cnt, last_en_cyc + 2);
    check("exp_left", exp_q.size(), 0);
    check("valid_left", vid_q.size(), 0);
  endtask

  task automatic run_seq(input int s, input int d, input int c, input bit stall);
    do_start(s, d, c);
    run_to_done(d, c, stall);
  endtask

  task automatic zero_seq(input int s, input int d, input int c);
    do_start(s, d, c);
    drive(1'b0);
    @(negedge clk); #1;
    check("done_after_zero_start", bus.done, 1);
    repeat (3) begin @(posedge clk); #1; drive(1'b0); end
    @(negedge clk); #1;
    check("zero_read_count", rd_cnt, 0);
    check("done_held", bus.done, 1);
  endtask

  task automatic wait_reads(input int unsigned target);
    int unsigned n = 0;
    bus.rd_req = 1'b1; bus.data_type = DT;
    @(negedge clk); #1;
    while (rd_cnt < target && n < 100) begin @(negedge clk); #1; n++; end
    check("reads_before_event", rd_cnt >= target, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.rd_req = 1'b0; bus.data_type = DT;
    bus.sram_num = '0; bus.data_num = '0; bus.cyc_num = '0;
    #1;
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_id", bus.rd_id, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_rd_valid_id", bus.rd_valid_id, 0);
    @(posedge clk); #3 rst_n = 1'b1;

    run_seq(4, 3, 2, 1'b0);
    run_seq(4, 10, 1, 1'b0);
    run_seq(4, 10, 1, 1'b1);
    zero_seq(4, 3, 0);
    zero_seq(4, 0, 2);
    zero_seq(0, 3, 2);
    run_seq(1, 15, 20, 1'b0);

    // Restart while a read is being issued: old read completes, new sequence starts at k=0.
    do_start(4, 10, 1);
    wait_reads(3);
    do_start(3, 7, 2);
    run_to_done(7, 2, 1'b0);

    // Asynchronous reset mid-sequence.
    do_start(4, 3, 2);
    wait_reads(3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd_en", bus.rd_en, 0);
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_rd_id", bus.rd_id, 0);
    check("midrst_rd_addr", bus.rd_addr, 0);
    check("midrst_rd_valid_id", bus.rd_valid_id, 0);
    exp_q.delete(); vid_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle_done", bus.done, 0);
    run_seq(4, 3, 2, 1'b0);

    for (int i = 0; i < 20; i++) begin
      int s, d, c;
      s = $urandom_range(1, 15);
      d = $urandom_range(1, 15);
      c = $urandom_range(1, 4);
      run_seq(s, d, c, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
